// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, baud rate codes and divider timing constants
package uart_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_APPLY, S_SETTLE, S_ACK, S_ERR, S_REL
  } state_t;
  localparam logic [1:0] BD_2400  = 2'b00;
  localparam logic [1:0] BD_4800  = 2'b01;
  localparam logic [1:0] BD_9600  = 2'b10;
  localparam logic [1:0] BD_19200 = 2'b11;
  localparam int DIV_2400   = 1302;
  localparam int DIV_4800   = 651;
  localparam int DIV_9600   = 325;
  localparam int DIV_19200  = 162;
  localparam int OVERSAMPLE = 16;
  // one TX tick spans OVERSAMPLE divider periods
  function automatic int tx_tick_cycles(input logic [1:0] rate);
    return OVERSAMPLE * (rate == BD_2400 ? DIV_2400 :
                         rate == BD_4800 ? DIV_4800 :
                         rate == BD_9600 ? DIV_9600 : DIV_19200);
  endfunction
endpackage

// File: rtl/cfg_timeout_timer.sv
// cfg_timeout_timer: clearable saturating up-counter flagging its last count
module cfg_timeout_timer #(
  parameter int LIMIT = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic term
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] TOP  = W'(LIMIT);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!reset || clr) cnt <= '0;
    else if (en && cnt != TOP) cnt <= cnt + 1'b1;
  assign term = cnt == LAST;
endmodule

// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl: drains TX/RX, reprograms the baud divider and waits for it to settle
module uart_baud_ctrl
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYC  = 65535,
  parameter int SETTLE_TICKS = 2
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       cfg_req,
  input  logic [1:0] cfg_rate,
  input  logic       tx_busy,
  input  logic       rx_busy,
  input  logic       clk_tx,
  output logic [1:0] bd_rate,
  output logic       div_reset,
  output logic       tx_hold,
  output logic       cfg_ack,
  output logic       cfg_err,
  output logic       busy
);
  localparam int TW = $clog2(SETTLE_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SETTLE_TICKS - 1);
  state_t state, nxt;
  logic [1:0] pend;
  logic [TW-1:0] ticks;
  logic idle, expired;
  assign idle = !tx_busy && !rx_busy;
  cfg_timeout_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
    .clk  (clk_50M),
    .reset(reset),
    .clr  (state != S_DRAIN),
    .en   (state == S_DRAIN && !idle),
    .term (expired)
  );
  // div_reset is registered so the divider also sits in reset while we do
  always_ff @(posedge clk_50M)
    if (!reset) begin
      state     <= S_IDLE;
      bd_rate   <= BD_2400;
      pend      <= BD_2400;
      div_reset <= 1'b1;
      ticks     <= '0;
    end else begin
      state     <= nxt;
      div_reset <= nxt == S_APPLY;
      if (state == S_IDLE && cfg_req) pend <= cfg_rate;
      if (nxt == S_APPLY) bd_rate <= pend;
      ticks <= state != S_SETTLE ? '0 : clk_tx ? ticks + 1'b1 : ticks;
    end
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (cfg_req) nxt = cfg_rate == bd_rate ? S_ACK : S_DRAIN;
      S_DRAIN:  nxt = idle ? S_APPLY : expired ? S_ERR : S_DRAIN;
      S_APPLY:  nxt = S_SETTLE;
      S_SETTLE: if (clk_tx && ticks == TICK_LAST) nxt = S_ACK;
      S_ACK:    nxt = S_REL;
      S_ERR:    nxt = S_REL;
      S_REL:    if (!cfg_req) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
    tx_hold = state != S_IDLE && state != S_REL;
    cfg_ack = state == S_ACK;
    cfg_err = state == S_ERR;
    busy    = state != S_IDLE;
  end
endmodule

// File: tb/tb_uart_baud_ctrl.sv
// tb_uart_baud_ctrl: randomized request timelines checked against a phase-boundary model
module tb_uart_baud_ctrl;
  import uart_pkg::*;
  localparam int TO = 16;
  localparam int ST = 2;
  logic clk_50M = 0, reset = 0, cfg_req = 0, tx_busy = 0, rx_busy = 0, clk_tx = 0;
  logic [1:0] cfg_rate = 0, bd_rate;
  logic div_reset, tx_hold, cfg_ack, cfg_err, busy;
  logic [1:0] model_bd = BD_2400;
  int n_cmp = 0, n_bad = 0;
  always #10 clk_50M = ~clk_50M;
  uart_baud_ctrl #(.TIMEOUT_CYC(TO), .SETTLE_TICKS(ST)) dut (
    .clk_50M(clk_50M), .reset(reset), .cfg_req(cfg_req), .cfg_rate(cfg_rate),
    .tx_busy(tx_busy), .rx_busy(rx_busy), .clk_tx(clk_tx), .bd_rate(bd_rate),
    .div_reset(div_reset), .tx_hold(tx_hold), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .busy(busy)
  );
  // vector layout: {bd_rate, div_reset, tx_hold, cfg_ack, cfg_err, busy}
  function automatic logic [6:0] obs();
    return {bd_rate, div_reset, tx_hold, cfg_ack, cfg_err, busy};
  endfunction
  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {bd,div,hold,ack,err,busy}=%b want %b", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask
  // k indexes the cycle after edge E_k, E0 being the edge that accepts the request.
  // Busy is held through edge E_b, ticks land g and 2g edges after the APPLY-leaving edge.
  task automatic run_req(input string name, input logic [1:0] rate, input int b,
                         input bit on_rx, input int g, input int h, input bit spur,
                         input int abort);
    bit same = rate == model_bd;
    bit tout = !same && b >= TO;
    int a = b + 1;
    int t1 = a + 1 + g;
    int t2 = a + 1 + 2 * g;
    int fin = same ? 0 : tout ? TO : t2;
    int idle_k = h + 1 > 2 ? fin + h + 1 : fin + 2;
    bit settle = !same && !tout;
    logic [1:0] eb;
    for (int k = 0; k <= idle_k; k++) begin
      cfg_req  = k <= fin + h;
      cfg_rate = k == 0 ? rate : 2'($urandom_range(0, 3));
      tx_busy  = !on_rx && k <= b;
      rx_busy  = on_rx && k <= b;
      clk_tx   = (settle && (k == t1 || k == t2 || (spur && k == a + 1))) ||
                 (!same && k < (tout ? TO : a) && $urandom_range(0, 3) == 0);
      if (k == abort) reset = 0;
      tick();
      if (k == abort) begin
        check($sformatf("%s reset", name), obs(), 7'b00_1_0_0_0_0);
        reset = 1; cfg_req = 0; tx_busy = 0; rx_busy = 0;
        model_bd = BD_2400;
        for (int j = 0; j < 3 * g + 4; j++) begin
          clk_tx = j % g == 0;
          tick();
          check($sformatf("%s post j=%0d", name, j), obs(), 7'b0);
        end
        clk_tx = 0;
        return;
      end
      eb = settle && k >= a ? rate : model_bd;
      check($sformatf("%s k=%0d", name, k), obs(),
            {eb, settle && k == a, k <= fin, !tout && k == fin, tout && k == fin, k < idle_k});
    end
    tx_busy = 0; rx_busy = 0; clk_tx = 0;
    if (settle) model_bd = rate;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_hold %0d", i), obs(), 7'b00_1_0_0_0_0);
    end
    reset = 1;
    tick();
    check("rst_rel", obs(), 7'b0);
    run_req("chg_00_11", BD_19200, 0, 0, tx_tick_cycles(BD_19200), 3, 1, -1);
    run_req("drain_tx", BD_4800, 12, 0, 5, 2, 1, -1);
    run_req("drain_edge", BD_9600, TO - 1, 1, 3, 0, 0, -1);
    run_req("same_rate", BD_9600, 0, 0, 1, 10, 0, -1);
    run_req("timeout", BD_2400, TO + 20, 1, 1, 1, 0, -1);
    run_req("abort_settle", BD_19200, 2, 0, 20, 0, 0, 14);
    run_req("after_abort", BD_4800, 0, 1, 2, 1, 0, -1);
    for (int n = 0; n < 40; n++)
      run_req($sformatf("rnd%0d", n), 2'($urandom_range(0, 3)), $urandom_range(0, TO + 4),
              1'($urandom_range(0, 1)), $urandom_range(1, 8), $urandom_range(0, 4),
              1'($urandom_range(0, 1)), -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
